// File: rtl/timer_apb_ctrl.sv
// APB4 slave front-end for the timer register file: sequences each transfer into
// single-cycle wr_en/rd_en strobes. Optional wait states under `TIMER_APB_WAIT_EN.
module timer_apb_ctrl #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 12'h1C,
  parameter int                WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic [3:0]        strb,
  input  logic [31:0]       rdata,
  input  logic              reg_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

`ifdef TIMER_APB_WAIT_EN
  localparam bit WAIT_ON = 1'b1;
`else
  localparam bit WAIT_ON = 1'b0;
`endif

  // Effective per-transfer wait count, clamped to what the 4-bit counter holds.
  localparam logic [3:0] WAIT_EFF = !WAIT_ON      ? 4'd0 :
                                    (WAIT_CYC > 15) ? 4'd15 :
                                    (WAIT_CYC < 0)  ? 4'd0 : 4'(WAIT_CYC);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        strb_reg;
  logic              pwrite_q_reg;
  logic              addr_err_reg;
  logic              setup;
  logic              wait_last;
  logic              access_hs;

  assign setup = psel & ~penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      strb_reg     <= '0;
      pwrite_q_reg <= 1'b0;
      addr_err_reg <= 1'b0;
    end else if (state_reg == IDLE && setup) begin
      addr_reg     <= paddr;
      wdata_reg    <= pwdata;
      strb_reg     <= pwrite ? pstrb : 4'h0;
      pwrite_q_reg <= pwrite;
      addr_err_reg <= (paddr[1:0] != 2'b00) || (paddr > ADDR_MAX);
    end
  end

`ifdef TIMER_APB_WAIT_EN
  logic [3:0] wait_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 4'd0;
    end else if (state_reg == IDLE && setup) begin
      wait_cnt_reg <= WAIT_EFF;
    end else if (state_reg == WAIT && psel) begin
      wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end
  end

  assign wait_last = (wait_cnt_reg == 4'd1);
`else
  assign wait_last = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // A select with penable already high is a protocol violation and is ignored.
        if (setup) begin
          state_next = (WAIT_EFF != 4'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (wait_last) begin
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    access_hs = (state_reg == ACCESS) & psel & penable;
    pready    = access_hs;
    wr_en     = access_hs & pwrite_q_reg & ~addr_err_reg;
    rd_en     = access_hs & ~pwrite_q_reg & ~addr_err_reg;
    prdata    = rd_en ? rdata : 32'h0;
    pslverr   = access_hs & (addr_err_reg | (wr_en & reg_err));
  end

  assign addr  = addr_reg;
  assign wdata = wdata_reg;
  assign strb  = strb_reg;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Randomized bench for timer_apb_ctrl: a transaction-level register model predicts
// every response; a simple register-file stub sits on the back end.
module tb_timer_apb_ctrl;

  localparam int ADDR_W   = 12;
  localparam int WAIT_CYC = 2;
`ifdef TIMER_APB_WAIT_EN
  localparam int WAIT_N = (WAIT_CYC > 15) ? 15 : WAIT_CYC;
`else
  localparam int WAIT_N = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        strb;
  logic [31:0]       rdata;
  logic              reg_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf_mem  [8];
  logic [31:0] exp_mem [8];

  timer_apb_ctrl #(
    .ADDR_W  (ADDR_W),
    .ADDR_MAX(12'h1C),
    .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wdata  (wdata),
    .strb   (strb),
    .rdata  (rdata),
    .reg_err(reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stub: combinational read, byte-strobed commit unless it flags an error.
  assign rdata = rf_mem[addr[4:2]];
  always @(posedge clk) begin
    if (wr_en && !reg_err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) rf_mem[addr[4:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [11:0] a);
    return (a[1:0] == 2'b00) && (a <= 12'h1C);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"},  32'(pready),  32'd0);
    chk({tag, "_pslverr"}, 32'(pslverr), 32'd0);
    chk({tag, "_wr_en"},   32'(wr_en),   32'd0);
    chk({tag, "_rd_en"},   32'(rd_en),   32'd0);
    chk({tag, "_prdata"},  prdata,       32'd0);
  endtask

  // One full transfer starting with a setup phase; leaves psel high after completion.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit ferr, output logic [31:0] rd_out);
    int          lat;
    int          wr_seen;
    int          rd_seen;
    bit          done;
    bit          ok;
    logic        got_err;
    logic [11:0] got_addr;
    logic [31:0] got_wdata;
    logic [3:0]  got_strb;
    logic [31:0] exp_rd;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; reg_err = ferr;
    lat = 0; wr_seen = 0; rd_seen = 0; done = 1'b0;
    rd_out = 32'hDEAD_BEEF; got_err = 1'bx;
    got_addr = 'x; got_wdata = 'x; got_strb = 'x;
    while (!done && lat < 40) begin
      @(negedge clk);
      // Scramble the bus after setup: the latched copies must not follow it.
      penable = 1'b1; paddr = 12'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
      #1;
      lat++;
      wr_seen += int'(wr_en);
      rd_seen += int'(rd_en);
      if (pready) begin
        done = 1'b1;
        rd_out = prdata; got_err = pslverr;
        got_addr = addr; got_wdata = wdata; got_strb = strb;
      end
    end
    ok     = addr_ok(a);
    exp_rd = (!wr && ok) ? exp_mem[a[4:2]] : 32'h0;
    chk("latency", 32'(lat),     32'(1 + WAIT_N));
    chk("pslverr", 32'(got_err), 32'(!ok || (wr && ferr)));
    chk("prdata",  rd_out,       exp_rd);
    chk("wr_cnt",  32'(wr_seen), 32'(wr && ok));
    chk("rd_cnt",  32'(rd_seen), 32'(!wr && ok));
    chk("addr",    32'(got_addr),  32'(a));
    chk("wdata",   got_wdata,      d);
    chk("strb",    32'(got_strb),  wr ? 32'(s) : 32'd0);
    if (wr && ok && !ferr) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) exp_mem[a[4:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
    $display("xfer %s a=%h d=%h s=%h ferr=%0b lat=%0d err=%0b prdata=%h",
             wr ? "wr" : "rd", a, d, s, ferr, lat, got_err, rd_out);
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; reg_err = 1'b0;
    #1;
    chk("idle_strobe", 32'(wr_en | rd_en | pready), 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; reg_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("rst");
    chk("rst_addr",  32'(addr), 32'd0);
    chk("rst_wdata", wdata,     32'd0);
    chk("rst_strb",  32'(strb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("post_rst");

    // Populate every register with known contents.
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 12'(i * 4), $urandom, 4'hF, 1'b0, rd);
      idle_cyc();
    end

    // Zero-wait write then read back.
    xfer(1'b1, 12'h00C, 32'h1234_5678, 4'hF, 1'b0, rd);
    idle_cyc();
    xfer(1'b0, 12'h00C, 32'h0, 4'hF, 1'b0, rd);
    chk("readback_0c", rd, 32'h1234_5678);
    idle_cyc();

    // Read of a known value at 0x14.
    xfer(1'b1, 12'h014, 32'h0000_0001, 4'hF, 1'b0, rd);
    idle_cyc();
    xfer(1'b0, 12'h014, 32'h0, 4'h0, 1'b0, rd);
    chk("read_14", rd, 32'h1);
    idle_cyc();

    // Address decode errors.
    xfer(1'b0, 12'h020, 32'h0, 4'hF, 1'b0, rd);
    idle_cyc();
    xfer(1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    idle_cyc();

    // Register-file write error, and a read that must ignore it.
    xfer(1'b1, 12'h000, 32'hA5A5_A5A5, 4'hF, 1'b1, rd);
    idle_cyc();
    xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, rd);
    idle_cyc();

    // Zero-strobe write, then partial-strobe write.
    xfer(1'b1, 12'h018, 32'hCAFE_F00D, 4'h0, 1'b0, rd);
    idle_cyc();
    xfer(1'b1, 12'h018, 32'hCAFE_F00D, 4'h5, 1'b0, rd);
    idle_cyc();
    xfer(1'b0, 12'h018, 32'h0, 4'h0, 1'b0, rd);
    idle_cyc();

    // Abort: psel dropped one cycle after setup.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
    chk_all_zero("abort1");
    @(negedge clk);
    #1;
    chk_all_zero("abort2");
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, rd);
    idle_cyc();

    // Reset pulsed in the middle of a transfer.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_addr",  32'(addr), 32'd0);
    chk("midrst_wdata", wdata,     32'd0);
    chk("midrst_strb",  32'(strb), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 12'h014, 32'h0, 4'h0, 1'b0, rd);
    chk("midrst_kept", rd, 32'h1);
    idle_cyc();

    // Protocol violation: select with penable already high from IDLE.
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h01C; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    #1;
    chk_all_zero("viol1");
    @(negedge clk);
    #1;
    chk_all_zero("viol2");
    idle_cyc();
    xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, rd);
    idle_cyc();

    // Back-to-back write then read.
    xfer(1'b1, 12'h008, 32'h0F0F_1234, 4'hF, 1'b0, rd);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd);
    chk("b2b_read", rd, 32'h0F0F_1234);
    idle_cyc();

    // Randomized traffic, mixed idle and back-to-back.
    for (int n = 0; n < 150; n++) begin
      int          r;
      logic [11:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 12'(r * 4);
      else if (r == 8) a = 12'({$urandom_range(0, 7), 2'b00} | $urandom_range(1, 3));
      else             a = 12'(12'h020 + 4 * $urandom_range(0, 1000));
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
           ($urandom_range(0, 7) == 0), rd);
      if ($urandom_range(0, 1) == 0) idle_cyc();
    end
    idle_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
